// File: rtl/vga_pkg.sv
// Default 640x480@60 VGA timing constants, derived counter widths and the coordinate type
// shared by the timing generator and its coordinate counters.
package vga_pkg;

    localparam int unsigned PIPELINE_STAGES = 2;

    localparam int unsigned H_VISIBLE_AREA = 640;
    localparam int unsigned H_FRONT_PORCH  = 16;
    localparam int unsigned H_SYNC_PULSE   = 96;
    localparam int unsigned H_BACK_PORCH   = 48;
    localparam int unsigned V_VISIBLE_AREA = 480;
    localparam int unsigned V_FRONT_PORCH  = 10;
    localparam int unsigned V_SYNC_PULSE   = 2;
    localparam int unsigned V_BACK_PORCH   = 33;

    localparam int unsigned H_WHOLE_LINE =
        H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int unsigned V_WHOLE_LINE =
        V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam int unsigned HW = $clog2(H_WHOLE_LINE);
    localparam int unsigned VW = $clog2(V_WHOLE_LINE);

    typedef struct packed {
        logic [HW-1:0] x;
        logic [VW-1:0] y;
    } vga_coord_t;

endpackage

// File: rtl/vga_coord_counter.sv
// Wrapping x/y raster counter with synchronous load of an initial coordinate.
// coord_nxt exposes the value the counter takes on the next edge.
module vga_coord_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_WHOLE = H_WHOLE_LINE,
    parameter int unsigned V_WHOLE = V_WHOLE_LINE,
    parameter int unsigned XW      = HW,
    parameter int unsigned YW      = VW,
    parameter type         coord_t = vga_coord_t
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step,
    input  logic   load,
    input  coord_t init,
    output coord_t coord,
    output coord_t coord_nxt
);

    always_comb begin
        coord_nxt = coord;
        if (load) begin
            coord_nxt = init;
        end else if (step) begin
            if (coord.x == XW'(H_WHOLE - 1)) begin
                coord_nxt.x = '0;
                if (coord.y == YW'(V_WHOLE - 1)) begin
                    coord_nxt.y = '0;
                end else begin
                    coord_nxt.y = coord.y + YW'(1);
                end
            end else begin
                coord_nxt.x = coord.x + XW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coord <= init;
        end else begin
            coord <= coord_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_lookahead.sv
// VGA timing generator: current raster pair with sync/DE plus a second pair LOOKAHEAD pixels ahead.
// Optional frame counter enabled with `define VGA_FRAME_COUNTER_EN.
module vga_timing_lookahead #(
    parameter int unsigned H_VISIBLE_AREA = vga_pkg::H_VISIBLE_AREA,
    parameter int unsigned H_FRONT_PORCH  = vga_pkg::H_FRONT_PORCH,
    parameter int unsigned H_SYNC_PULSE   = vga_pkg::H_SYNC_PULSE,
    parameter int unsigned H_BACK_PORCH   = vga_pkg::H_BACK_PORCH,
    parameter int unsigned V_VISIBLE_AREA = vga_pkg::V_VISIBLE_AREA,
    parameter int unsigned V_FRONT_PORCH  = vga_pkg::V_FRONT_PORCH,
    parameter int unsigned V_SYNC_PULSE   = vga_pkg::V_SYNC_PULSE,
    parameter int unsigned V_BACK_PORCH   = vga_pkg::V_BACK_PORCH,
    parameter int unsigned LOOKAHEAD      = vga_pkg::PIPELINE_STAGES,
    parameter logic        HS_POL         = 1'b0,
    parameter logic        VS_POL         = 1'b0,
    parameter int unsigned FRAME_CNT_W    = 16,
    localparam int unsigned H_WHOLE_LINE  =
        H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH,
    localparam int unsigned V_WHOLE_LINE  =
        V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH,
    localparam int unsigned HW = $clog2(H_WHOLE_LINE),
    localparam int unsigned VW = $clog2(V_WHOLE_LINE)
) (
    input  logic                   vga_pix_clk,
    input  logic                   rst_n,
    input  logic                   pix_stb,
    input  logic                   resync,
    output logic [HW-1:0]          sx,
    output logic [VW-1:0]          sy,
    output logic                   de,
    output logic                   hsync,
    output logic                   vsync,
    output logic [HW-1:0]          sx_aot,
    output logic [VW-1:0]          sy_aot,
    output logic                   de_aot,
    output logic                   line_stb_aot,
    output logic                   frame_stb_aot,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    if (LOOKAHEAD >= H_WHOLE_LINE || H_FRONT_PORCH == 0 || H_SYNC_PULSE == 0 ||
        H_BACK_PORCH == 0 || V_FRONT_PORCH == 0 || V_SYNC_PULSE == 0 ||
        V_BACK_PORCH == 0) begin : g_bad_params
        $error("vga_timing_lookahead: illegal timing or LOOKAHEAD parameters");
    end

    typedef struct packed {
        logic [HW-1:0] x;
        logic [VW-1:0] y;
    } coord_t;

    localparam coord_t CUR_INIT = '{x: '0, y: '0};
    localparam coord_t AOT_INIT = '{x: HW'(LOOKAHEAD), y: '0};

    function automatic logic is_visible(input coord_t c);
        return (c.x < HW'(H_VISIBLE_AREA)) && (c.y < VW'(V_VISIBLE_AREA));
    endfunction

    function automatic logic hsync_level(input logic [HW-1:0] x);
        return ((x >= HW'(H_VISIBLE_AREA + H_FRONT_PORCH)) &&
                (x <  HW'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE))) ? HS_POL : ~HS_POL;
    endfunction

    function automatic logic vsync_level(input logic [VW-1:0] y);
        return ((y >= VW'(V_VISIBLE_AREA + V_FRONT_PORCH)) &&
                (y <  VW'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE))) ? VS_POL : ~VS_POL;
    endfunction

    coord_t cur, cur_nxt, aot, aot_nxt;

    vga_coord_counter #(
        .H_WHOLE (H_WHOLE_LINE),
        .V_WHOLE (V_WHOLE_LINE),
        .XW      (HW),
        .YW      (VW),
        .coord_t (coord_t)
    ) u_cur (
        .clk       (vga_pix_clk),
        .rst_n     (rst_n),
        .step      (pix_stb),
        .load      (resync),
        .init      (CUR_INIT),
        .coord     (cur),
        .coord_nxt (cur_nxt)
    );

    vga_coord_counter #(
        .H_WHOLE (H_WHOLE_LINE),
        .V_WHOLE (V_WHOLE_LINE),
        .XW      (HW),
        .YW      (VW),
        .coord_t (coord_t)
    ) u_aot (
        .clk       (vga_pix_clk),
        .rst_n     (rst_n),
        .step      (pix_stb),
        .load      (resync),
        .init      (AOT_INIT),
        .coord     (aot),
        .coord_nxt (aot_nxt)
    );

    assign sx     = cur.x;
    assign sy     = cur.y;
    assign sx_aot = aot.x;
    assign sy_aot = aot.y;

    // Decoded from the counters' next values so flags line up with the coordinates they describe.
    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            de            <= is_visible(CUR_INIT);
            hsync         <= hsync_level(CUR_INIT.x);
            vsync         <= vsync_level(CUR_INIT.y);
            de_aot        <= is_visible(AOT_INIT);
            line_stb_aot  <= (AOT_INIT.x == '0);
            frame_stb_aot <= (AOT_INIT == '0);
        end else begin
            de            <= is_visible(cur_nxt);
            hsync         <= hsync_level(cur_nxt.x);
            vsync         <= vsync_level(cur_nxt.y);
            de_aot        <= is_visible(aot_nxt);
            line_stb_aot  <= (aot_nxt.x == '0);
            frame_stb_aot <= (aot_nxt == '0);
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   frame_wrap;

    assign frame_wrap = pix_stb && !resync &&
                        (cur.x == HW'(H_WHOLE_LINE - 1)) && (cur.y == VW'(V_WHOLE_LINE - 1));

    always_ff @(posedge vga_pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_wrap) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_timing_lookahead.sv
// Self-checking bench: three generator instances (default geometry, and two small geometries)
// compared every cycle against a linear pixel-index reference model.
module tb_vga_timing_lookahead;

    typedef struct packed {
        int hvis; int hfp; int hsp; int hbp;
        int vvis; int vfp; int vsp; int vbp;
        int la;   int hpol; int vpol;
    } geom_t;

    localparam geom_t GA = '{hvis: 640, hfp: 16, hsp: 96, hbp: 48,
                             vvis: 480, vfp: 10, vsp: 2, vbp: 33,
                             la: 2, hpol: 0, vpol: 0};
    localparam geom_t GB = '{hvis: 16, hfp: 2, hsp: 4, hbp: 3,
                             vvis: 6, vfp: 1, vsp: 2, vbp: 2,
                             la: 7, hpol: 1, vpol: 0};
    localparam geom_t GC = '{hvis: 16, hfp: 2, hsp: 4, hbp: 3,
                             vvis: 6, vfp: 1, vsp: 2, vbp: 2,
                             la: 0, hpol: 0, vpol: 1};

    logic clk, rst_n, pix_stb, resync;

    logic [9:0]  sx_a, sxa_a, sy_a, sya_a;
    logic        de_a, hs_a, vs_a, dea_a, lsa_a, fsa_a;
    logic [15:0] fc_a;
    logic [4:0]  sx_b, sxa_b, sx_c, sxa_c;
    logic [3:0]  sy_b, sya_b, sy_c, sya_c;
    logic        de_b, hs_b, vs_b, dea_b, lsa_b, fsa_b;
    logic        de_c, hs_c, vs_c, dea_c, lsa_c, fsa_c;
    logic [15:0] fc_b;
    logic [2:0]  fc_c;

    int n_checks = 0;
    int n_errors = 0;
    int ia, ib, ic, fa, fb, fc;

    vga_timing_lookahead u_dut_a (
        .vga_pix_clk (clk), .rst_n (rst_n), .pix_stb (pix_stb), .resync (resync),
        .sx (sx_a), .sy (sy_a), .de (de_a), .hsync (hs_a), .vsync (vs_a),
        .sx_aot (sxa_a), .sy_aot (sya_a), .de_aot (dea_a),
        .line_stb_aot (lsa_a), .frame_stb_aot (fsa_a), .frame_cnt (fc_a)
    );

    vga_timing_lookahead #(
        .H_VISIBLE_AREA (16), .H_FRONT_PORCH (2), .H_SYNC_PULSE (4), .H_BACK_PORCH (3),
        .V_VISIBLE_AREA (6),  .V_FRONT_PORCH (1), .V_SYNC_PULSE (2), .V_BACK_PORCH (2),
        .LOOKAHEAD (7), .HS_POL (1'b1), .VS_POL (1'b0), .FRAME_CNT_W (16)
    ) u_dut_b (
        .vga_pix_clk (clk), .rst_n (rst_n), .pix_stb (pix_stb), .resync (resync),
        .sx (sx_b), .sy (sy_b), .de (de_b), .hsync (hs_b), .vsync (vs_b),
        .sx_aot (sxa_b), .sy_aot (sya_b), .de_aot (dea_b),
        .line_stb_aot (lsa_b), .frame_stb_aot (fsa_b), .frame_cnt (fc_b)
    );

    vga_timing_lookahead #(
        .H_VISIBLE_AREA (16), .H_FRONT_PORCH (2), .H_SYNC_PULSE (4), .H_BACK_PORCH (3),
        .V_VISIBLE_AREA (6),  .V_FRONT_PORCH (1), .V_SYNC_PULSE (2), .V_BACK_PORCH (2),
        .LOOKAHEAD (0), .HS_POL (1'b0), .VS_POL (1'b1), .FRAME_CNT_W (3)
    ) u_dut_c (
        .vga_pix_clk (clk), .rst_n (rst_n), .pix_stb (pix_stb), .resync (resync),
        .sx (sx_c), .sy (sy_c), .de (de_c), .hsync (hs_c), .vsync (vs_c),
        .sx_aot (sxa_c), .sy_aot (sya_c), .de_aot (dea_c),
        .line_stb_aot (lsa_c), .frame_stb_aot (fsa_c), .frame_cnt (fc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hline(input geom_t g);
        return g.hvis + g.hfp + g.hsp + g.hbp;
    endfunction

    function automatic int ptot(input geom_t g);
        return hline(g) * (g.vvis + g.vfp + g.vsp + g.vbp);
    endfunction

    // Reference: each pair is a linear pixel index into the frame; frames count current-pair wraps.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ia <= 0; ib <= 0; ic <= 0;
            fa <= 0; fb <= 0; fc <= 0;
        end else if (resync) begin
            ia <= 0; ib <= 0; ic <= 0;
        end else if (pix_stb) begin
            ia <= (ia + 1) % ptot(GA);
            ib <= (ib + 1) % ptot(GB);
            ic <= (ic + 1) % ptot(GC);
            fa <= fa + ((ia == ptot(GA) - 1) ? 1 : 0);
            fb <= fb + ((ib == ptot(GB) - 1) ? 1 : 0);
            fc <= fc + ((ic == ptot(GC) - 1) ? 1 : 0);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input geom_t g, input int idx, input int frames,
                             input int fc_mod, input logic [31:0] sx, input logic [31:0] sy,
                             input logic de, input logic hs, input logic vs,
                             input logic [31:0] sxa, input logic [31:0] sya, input logic dea,
                             input logic lsa, input logic fsa, input logic [31:0] fcnt);
        int hl, x, y, a, xa, ya, ef;
        hl = hline(g);
        x  = idx % hl;
        y  = idx / hl;
        a  = (idx + g.la) % ptot(g);
        xa = a % hl;
        ya = a / hl;
`ifdef VGA_FRAME_COUNTER_EN
        ef = frames % fc_mod;
`else
        ef = 0;
`endif
        check_eq({tag, ".sx"}, sx, x);
        check_eq({tag, ".sy"}, sy, y);
        check_eq({tag, ".de"}, {31'd0, de}, (x < g.hvis && y < g.vvis) ? 1 : 0);
        check_eq({tag, ".hsync"}, {31'd0, hs},
                 (x >= g.hvis + g.hfp && x < g.hvis + g.hfp + g.hsp) ? g.hpol : 1 - g.hpol);
        check_eq({tag, ".vsync"}, {31'd0, vs},
                 (y >= g.vvis + g.vfp && y < g.vvis + g.vfp + g.vsp) ? g.vpol : 1 - g.vpol);
        check_eq({tag, ".sx_aot"}, sxa, xa);
        check_eq({tag, ".sy_aot"}, sya, ya);
        check_eq({tag, ".de_aot"}, {31'd0, dea}, (xa < g.hvis && ya < g.vvis) ? 1 : 0);
        check_eq({tag, ".line_stb_aot"}, {31'd0, lsa}, (xa == 0) ? 1 : 0);
        check_eq({tag, ".frame_stb_aot"}, {31'd0, fsa}, (a == 0) ? 1 : 0);
        check_eq({tag, ".frame_cnt"}, fcnt, ef);
    endtask

    task automatic check_all();
        check_dut("A", GA, ia, fa, 1 << 16, 32'(sx_a), 32'(sy_a), de_a, hs_a, vs_a,
                  32'(sxa_a), 32'(sya_a), dea_a, lsa_a, fsa_a, 32'(fc_a));
        check_dut("B", GB, ib, fb, 1 << 16, 32'(sx_b), 32'(sy_b), de_b, hs_b, vs_b,
                  32'(sxa_b), 32'(sya_b), dea_b, lsa_b, fsa_b, 32'(fc_b));
        check_dut("C", GC, ic, fc, 1 << 3, 32'(sx_c), 32'(sy_c), de_c, hs_c, vs_c,
                  32'(sxa_c), 32'(sya_c), dea_c, lsa_c, fsa_c, 32'(fc_c));
    endtask

    task automatic tick(input logic stb, input logic rs);
        pix_stb = stb;
        resync  = rs;
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst_n   = 1'b0;
        pix_stb = 1'b0;
        resync  = 1'b0;
        repeat (3) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Continuous pixel clock: covers line wraps of the default geometry and whole small frames.
        for (int i = 0; i < 1700; i++) tick(1'b1, 1'b0);

        // One pixel every fourth clock.
        for (int i = 0; i < 2400; i++) tick((i % 4) == 0, 1'b0);

        // Random enable with occasional resync.
        for (int i = 0; i < 3000; i++) tick(1'($urandom_range(0, 1)), $urandom_range(0, 199) == 0);

        // Resync while the pixel enable is low.
        for (int i = 0; i < 300; i++) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);

        // Asynchronous reset mid-frame with the pixel enable held high.
        for (int i = 0; i < 450; i++) tick(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 2500; i++) tick(1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
